segment_scan_driver: RTL

- Time-multiplexed driver for a bank of common-anode seven-segment digits. It is the scanned, parametrised successor to the single-digit hex-to-segment encoder.
- Holds a tear-free shadow copy of DIGITS hex nibbles plus per-digit decimal-point and blank flags.
- Cycles one active-low anode at a time, with a dead-time guard between slots to prevent ghosting.
- Sits between the board-level datapath and the segment/anode pins.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_scan_timer.sv | 54 +++++
 rtl/segment_scan_driver.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// ============================================================================
// Module   : seg_scan_pkg
// Purpose  : Shared constants and glyph encoding for the scanned 7-seg driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_scan_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low g..a patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] c_glyph_table = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [7:0] hex_to_glyph(input logic [3:0] nibble, input logic dp);
        return {~dp, c_glyph_table[nibble]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_timer.sv
// ============================================================================
// Module   : seg_scan_timer
// Purpose  : Slot divider and digit index for the scan; flags the frame wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_timer #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int IDX_W    = 3,
    parameter int DIV_W    = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [DIV_W-1:0] o_div_cnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_frame_wrap,
    output logic             o_frame_tick
);

    logic [DIV_W-1:0] r_div_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_frame_tick;
    logic             w_wrap;
    logic             w_last_digit;

    assign w_wrap       = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_last_digit = (r_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_wrap && w_last_digit;
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_idx     <= w_last_digit ? '0 : r_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign o_div_cnt    = r_div_cnt;
    assign o_idx        = r_idx;
    assign o_frame_wrap = w_wrap && w_last_digit;
    assign o_frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: rtl/segment_scan_driver.sv
// ============================================================================
// Module   : segment_scan_driver
// Purpose  : Multiplexed common-anode 7-seg driver with frame-aligned updates.
//            Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000,
    parameter int DEADTIME = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_tick,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            seg_data
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0]    w_div_cnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_frame_wrap;

    logic [4*DIGITS-1:0] r_stage_data;
    logic [DIGITS-1:0]   r_stage_dp;
    logic [DIGITS-1:0]   r_stage_blank;
    logic [4*DIGITS-1:0] r_shadow_data;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [DIGITS-1:0]   r_shadow_blank;
    logic                r_pending;
    logic [DIGITS-1:0]   r_anode;
    logic [7:0]          r_seg;

    logic [DIGITS-1:0]   w_suppress;
    logic [DIGITS-1:0]   w_anode_nxt;
    logic [7:0]          w_seg_nxt;
    logic [3:0]          w_nibble;
    logic                w_dead;

    seg_scan_timer #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .IDX_W    (IDX_W),
        .DIV_W    (DIV_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_div_cnt    (w_div_cnt),
        .o_idx        (w_idx),
        .o_frame_wrap (w_frame_wrap),
        .o_frame_tick (frame_tick)
    );

    // Staging always follows load so that it matches the shadow after a
    // load that lands directly on the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_data   <= '0;
            r_stage_dp     <= '0;
            r_stage_blank  <= '1;
            r_shadow_data  <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blank <= '1;
            r_pending      <= 1'b0;
            r_anode        <= '1;
            r_seg          <= SEG_OFF;
        end else begin
            if (load) begin
                r_stage_data  <= data_in;
                r_stage_dp    <= dp_in;
                r_stage_blank <= blank_in;
            end
            if (w_frame_wrap) begin
                r_shadow_data  <= load ? data_in  : r_stage_data;
                r_shadow_dp    <= load ? dp_in    : r_stage_dp;
                r_shadow_blank <= load ? blank_in : r_stage_blank;
                r_pending      <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_anode <= w_anode_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // Walk down from the top digit; the run breaks at the first shown digit.
    always_comb begin
        w_suppress = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run    = w_zero_run && (r_shadow_data[4*i +: 4] == 4'h0) && !r_shadow_dp[i];
            w_suppress[i] = w_zero_run;
        end
    end
`else
    assign w_suppress = '0;
`endif

    assign w_nibble = r_shadow_data[4*w_idx +: 4];
    assign w_dead   = (int'(w_div_cnt) < DEADTIME);

    always_comb begin
        w_anode_nxt = '1;
        w_seg_nxt   = SEG_OFF;
        if (!w_dead) begin
            w_anode_nxt[w_idx] = 1'b0;
            if (!r_shadow_blank[w_idx] && !w_suppress[w_idx]) begin
                w_seg_nxt = hex_to_glyph(w_nibble, r_shadow_dp[w_idx]);
            end
        end
    end

    assign pending  = r_pending;
    assign anode    = r_anode;
    assign seg_data = r_seg;

endmodule

`default_nettype wire
